// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory responder.
//   state_t           : responder FSM states (IDLE, WAIT, RESP)
//   NOP_INST          : word returned for misaligned / out-of-range fetches
//   DEFAULT_BASE_ADDR : byte address of instruction word 0
// ----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST          = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/imem_array.sv
// ----------------------------------------------------------------------------
// imem_array
// DEPTH x 32-bit instruction storage. Not reset.
// Optional feature macro: IMEM_PARITY_EN (one even-parity bit per word).
// Ports:
//   clk        : clock, write on rising edge
//   wr_en      : write one word
//   wr_idx     : word index to write
//   wr_data    : word to write
//   par_inj    : (IMEM_PARITY_EN only) invert the stored parity bit
//   rd_idx     : word index to read
//   rd_word    : stored word at rd_idx (combinational)
//   rd_par_ok  : 1 = parity of rd_word matches its stored bit
//                (tied 1 when parity is not built)
// ----------------------------------------------------------------------------
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
`ifdef IMEM_PARITY_EN
    input  logic          par_inj,
`endif
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_word,
    output logic          rd_par_ok
);

    logic [31:0] mem [DEPTH];

    // Read is combinational; the caller registers it on its sample edge, so a
    // write on that same edge is not seen (old word returned).
    assign rd_word = mem[rd_idx];

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx]     <= wr_data;
            // Even parity: stored bit makes the total count of ones even.
            par_mem[wr_idx] <= (^wr_data) ^ par_inj;
        end
    end

    assign rd_par_ok = ((^mem[rd_idx]) == par_mem[rd_idx]);
`else
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_par_ok = 1'b1;
`endif

endmodule

// File: rtl/imem_resp.sv
// ----------------------------------------------------------------------------
// imem_resp
// Instruction-memory responder: accepts a fetch pc, returns the instruction
// word LATENCY cycles after the accept edge, flags misaligned/out-of-range
// fetches, and offers a load port to preload the program image.
// Optional feature macro: IMEM_PARITY_EN (adds par_inj, parity error flag).
//
// Handshakes (both request and response side): a transfer happens on a rising
// edge where valid && ready are both 1. The source holds valid (and its data)
// until that edge; ready may be asserted independently of valid.
//
// Ports:
//   clk, rst            : clock; asynchronous active-low reset
//   req_valid/req_ready : fetch request handshake, req_addr = byte pc
//   resp_valid/resp_ready: response handshake, resp_inst/resp_err payload
//   load_en/idx/data    : write one word into storage (any state)
//   par_inj             : (IMEM_PARITY_EN) invert parity of the loaded word
//   state_dbg           : current FSM state
// ----------------------------------------------------------------------------
module imem_resp
    import imem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_inst,
    output logic                     resp_err,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [31:0]              load_data,
`ifdef IMEM_PARITY_EN
    input  logic                     par_inj,
`endif
    output state_t                   state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    // 33-bit bounds so BASE_ADDR + 4*DEPTH cannot wrap past 2^32.
    localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] ADDR_HI = ADDR_LO + (33'(DEPTH) << 2);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic          addr_err;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic          rd_par_ok;

    assign addr_err = (addr_q[1:0] != 2'b00)
                   || ({1'b0, addr_q} <  ADDR_LO)
                   || ({1'b0, addr_q} >= ADDR_HI);

    // Index only matters when the range check passed; truncation is safe then.
    assign rd_idx = AW'((addr_q - BASE_ADDR) >> 2);

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .wr_en     (load_en),
        .wr_idx    (load_idx),
        .wr_data   (load_data),
`ifdef IMEM_PARITY_EN
        .par_inj   (par_inj),
`endif
        .rd_idx    (rd_idx),
        .rd_word   (rd_word),
        .rd_par_ok (rd_par_ok)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_inst  <= '0;
            resp_err   <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        // Address errors return NOP; a parity error keeps the
                        // stored word so the bad contents can be inspected.
                        resp_inst  <= addr_err ? NOP_INST : rd_word;
                        resp_err   <= addr_err | ~rd_par_ok;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_imem_resp.sv
// ----------------------------------------------------------------------------
// tb_imem_resp
// Two responders share clock, reset and load port: u0 with LATENCY=2 and
// u1 with LATENCY=3. A transaction-level model predicts every output each
// cycle; directed fetches add literal expectations.
// ----------------------------------------------------------------------------
module tb_imem_resp;
    import imem_pkg::*;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT0  = 2;
    localparam int          LAT1  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_inst  [2];
    logic        resp_err   [2];
    state_t      state_dbg  [2];
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_data;
`ifdef IMEM_PARITY_EN
    logic        par_inj;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    imem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT0)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_inst(resp_inst[0]), .resp_err(resp_err[0]),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
`ifdef IMEM_PARITY_EN
        .par_inj(par_inj),
`endif
        .state_dbg(state_dbg[0])
    );

    imem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_inst(resp_inst[1]), .resp_err(resp_err[1]),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
`ifdef IMEM_PARITY_EN
        .par_inj(par_inj),
`endif
        .state_dbg(state_dbg[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m     [DEPTH];
    bit          par_bad_m [DEPTH];

    always @(posedge clk) begin
        if (load_en) begin
            mem_m[load_idx] <= load_data;
`ifdef IMEM_PARITY_EN
            par_bad_m[load_idx] <= par_inj;
`else
            par_bad_m[load_idx] <= 1'b0;
`endif
        end
    end

    // phase: 0 = ready for a request, 1 = fetch in flight, 2 = response held
    int          m_phase [2] = '{0, 0};
    longint      m_acc   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_inst  [2] = '{32'h0, 32'h0};
    logic        m_err   [2] = '{1'b0, 1'b0};
    longint      cyc = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        longint a;
        int     wi;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0;
                m_inst[i]  = 32'h0;
                m_err[i]   = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                case (m_phase[i])
                    0: if (req_valid[i]) begin
                        m_phase[i] = 1;
                        m_acc[i]   = cyc;
                        m_addr[i]  = req_addr[i];
                    end
                    1: if (cyc == m_acc[i] + lat_of(i)) begin
                        a = longint'(m_addr[i]);
                        if ((a % 4) != 0 || a < longint'(BASE) ||
                            a >= longint'(BASE) + 4 * DEPTH) begin
                            m_inst[i] = NOP_INST;
                            m_err[i]  = 1'b1;
                        end else begin
                            wi = int'((a - longint'(BASE)) / 4);
                            m_inst[i] = mem_m[wi];
                            m_err[i]  = par_bad_m[wi];
                        end
                        m_phase[i] = 2;
                    end
                    default: if (resp_ready[i]) m_phase[i] = 0;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d_req_ready", i), 32'(req_ready[i]), 32'(m_phase[i] == 0));
                check($sformatf("u%0d_resp_valid", i), 32'(resp_valid[i]), 32'(m_phase[i] == 2));
                if (m_phase[i] == 2) begin
                    check($sformatf("u%0d_resp_inst", i), resp_inst[i], m_inst[i]);
                    check($sformatf("u%0d_resp_err", i), 32'(resp_err[i]), 32'(m_err[i]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input int idx, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = 10'(idx);
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // One fetch on instance i. load_at >= 0 injects a load at that many
    // negedges after the accept edge. hold = cycles resp_ready stays low.
    // req_in_hold keeps req_valid high during the hold and after handshake.
    task automatic fetch(input int i, input logic [31:0] addr, input int hold,
                         input bit req_in_hold, input int load_at,
                         input int l_idx, input logic [31:0] l_data,
                         output logic [31:0] inst, output logic err, output int lat);
        int k;
        inst = 'x;
        err  = 1'bx;
        lat  = -1;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_addr[i]  = addr;
        k = 0;
        while (!req_ready[i] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[i]) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid[i] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_addr[i]  = ~addr;
        lat = 0;
        while (!resp_valid[i] && lat < 50) begin
            if (lat == load_at) begin
                load_en   = 1'b1;
                load_idx  = 10'(l_idx);
                load_data = l_data;
            end
            @(negedge clk);
            load_en = 1'b0;
            lat++;
        end
        if (!resp_valid[i]) begin
            check("resp_timeout", 32'd0, 32'd1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            if (req_in_hold) begin
                req_valid[i] = 1'b1;
                req_addr[i]  = addr;
            end
            @(negedge clk);
        end
        inst = resp_inst[i];
        err  = resp_err[i];
        resp_ready[i] = 1'b1;
        @(negedge clk);
        resp_ready[i] = 1'b0;
    endtask

    // ---------------- directed test ----------------
    logic [31:0] e_addr [4] = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_1000, 32'h8000_0FFC};
    logic        e_err  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] e_inst [4] = '{32'h13, 32'h13, 32'h13, 32'h0000_006F};

    initial begin : stim
        logic [31:0] inst;
        logic        err;
        int          lat;
        int          k;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_addr[i]   = 32'h0;
            resp_ready[i] = 1'b0;
        end
        load_en   = 1'b0;
        load_idx  = '0;
        load_data = '0;
`ifdef IMEM_PARITY_EN
        par_inj   = 1'b0;
`endif
        // Preload while in reset; storage is not cleared by reset.
        do_load(0, 32'h0000_0297);
        chk_en = 1'b1;
        do_load(1, 32'h1111_0001);
        do_load(1023, 32'h0000_006F);
        do_load(2, 32'h00A0_0113);

        check("rst_req_ready", 32'(req_ready[0]), 32'd1);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_resp_inst", resp_inst[0], 32'h0);
        check("rst_resp_err", 32'(resp_err[0]), 32'd0);
        check("rst_state", 32'(state_dbg[0]), 32'(IDLE));

        @(negedge clk);
        rst = 1'b1;

        // Aligned fetch, both latencies.
        fetch(0, 32'h8000_0000, 0, 1'b0, -1, 0, 32'h0, inst, err, lat);
        check("lat2", 32'(lat), 32'd2);
        check("word0_inst", inst, 32'h0000_0297);
        check("word0_err", 32'(err), 32'd0);
        fetch(1, 32'h8000_0000, 0, 1'b0, -1, 0, 32'h0, inst, err, lat);
        check("lat3", 32'(lat), 32'd3);
        check("word0_inst_l3", inst, 32'h0000_0297);

        // Backpressure with a request already waiting.
        fetch(0, 32'h8000_0FFC, 5, 1'b1, -1, 0, 32'h0, inst, err, lat);
        check("bp_inst", inst, 32'h0000_006F);
        check("bp_err", 32'(err), 32'd0);
        check("bp_ready_after_hs", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("bp_accepted_next", 32'(req_ready[0]), 32'd0);
        k = 0;
        while (!resp_valid[0] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("bp_second_resp", 32'(resp_valid[0]), 32'd1);
        resp_ready[0] = 1'b1;
        @(negedge clk);
        resp_ready[0] = 1'b0;

        // Address error table.
        for (int t = 0; t < 4; t++) begin
            fetch(0, e_addr[t], 0, 1'b0, -1, 0, 32'h0, inst, err, lat);
            check($sformatf("err_tab%0d_err", t), 32'(err), 32'(e_err[t]));
            check($sformatf("err_tab%0d_inst", t), inst, e_inst[t]);
        end

        // Load/read collision on LATENCY=3.
        fetch(1, 32'h8000_0004, 0, 1'b0, 1, 1, 32'hAAAA_0001, inst, err, lat);
        check("coll_early_new", inst, 32'hAAAA_0001);
        fetch(1, 32'h8000_0004, 0, 1'b0, 2, 1, 32'hBBBB_0001, inst, err, lat);
        check("coll_same_edge_old", inst, 32'hAAAA_0001);
        fetch(1, 32'h8000_0004, 0, 1'b0, -1, 0, 32'h0, inst, err, lat);
        check("coll_later_visible", inst, 32'hBBBB_0001);

        // Asynchronous reset during WAIT.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8000_0000;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("midrst_in_wait", 32'(req_ready[0]), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("midrst_async_ready", 32'(req_ready[0]), 32'd1);
        check("midrst_async_valid", 32'(resp_valid[0]), 32'd0);
        check("midrst_async_state", 32'(state_dbg[0]), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_resp", 32'(resp_valid[0]), 32'd0);
        check("midrst_ready_after", 32'(req_ready[0]), 32'd1);
        fetch(0, 32'h8000_0000, 0, 1'b0, -1, 0, 32'h0, inst, err, lat);
        check("midrst_next_inst", inst, 32'h0000_0297);
        check("midrst_next_lat", 32'(lat), 32'd2);

`ifdef IMEM_PARITY_EN
        par_inj = 1'b1;
        do_load(2, 32'h00A0_0113);
        par_inj = 1'b0;
        fetch(0, 32'h8000_0008, 0, 1'b0, -1, 0, 32'h0, inst, err, lat);
        check("par_bad_err", 32'(err), 32'd1);
        check("par_bad_inst", inst, 32'h00A0_0113);
        do_load(2, 32'h00A0_0113);
        fetch(0, 32'h8000_0008, 0, 1'b0, -1, 0, 32'h0, inst, err, lat);
        check("par_ok_err", 32'(err), 32'd0);
`else
        fetch(0, 32'h8000_0008, 0, 1'b0, -1, 0, 32'h0, inst, err, lat);
        check("word2_err", 32'(err), 32'd0);
        check("word2_inst", inst, 32'h00A0_0113);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        bad++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
